// File: rtl/mac_dot_ctrl.sv
// rtl/mac_dot_ctrl.sv - dot-product sequencer wrapped around an external pipelined MAC
//
// Feeds operand pairs into an external multiply-accumulate block and sums
// the returned products into a 48-bit result. The MAC latency is fixed by
// MAC_LAT. A tag shift register follows each accepted pair through the MAC
// pipeline, so the matching product is summed exactly when it arrives.
//
// Ports:
//   CLK, RST_N             clock (rising edge); asynchronous active-low reset
//   START, CFG_LEN         begin one dot product of CFG_LEN products (0 = 256)
//   IN_VALID/IN_READY      operand handshake; IN_A (25b signed), IN_B (18b signed)
//   MAC_A/B/C/D            operands to the MAC; C and D are tied to zero
//   MAC_SCLR               synchronous clear to the MAC, high while idle
//   MAC_P                  MAC result, MAC_LAT cycles after its operands
//   OUT_VALID/OUT_READY    result handshake; OUT_SUM (48b signed)
//   BUSY                   high whenever a run is in progress

module mac_dot_ctrl #(
    parameter int MAC_LAT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [7:0]  CFG_LEN,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [24:0] IN_A,
    input  logic [17:0] IN_B,
    output logic [24:0] MAC_A,
    output logic [17:0] MAC_B,
    output logic [47:0] MAC_C,
    output logic [24:0] MAC_D,
    output logic        MAC_SCLR,
    input  logic [47:0] MAC_P,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [47:0] OUT_SUM,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [8:0]         len_q;
    logic [8:0]         issue_q;
    logic [8:0]         retire_q;
    logic [47:0]        acc_q;
    logic [47:0]        sum_q;
    logic [MAC_LAT-1:0] tag_q;
    logic [MAC_LAT-1:0] tag_d;

    logic [8:0]         len_cfg;
    logic               accept;
    logic               last_accept;
    logic               collecting;
    logic               retire;
    logic               last_retire;

    always_comb begin
        // A length of zero encodes the full 256-product run.
        len_cfg     = (CFG_LEN == 8'd0) ? 9'd256 : {1'b0, CFG_LEN};
        accept      = (state_q == S_FEED) && IN_VALID;
        last_accept = accept && ((issue_q + 9'd1) == len_q);
        collecting  = (state_q == S_FEED) || (state_q == S_DRAIN);
        // The top tag bit marks the cycle in which MAC_P carries a product
        // belonging to this run.
        retire      = collecting && tag_q[MAC_LAT-1];
        last_retire = retire && ((retire_q + 9'd1) == len_q);
        tag_d       = tag_q << 1;
        tag_d[0]    = accept;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (last_retire) begin
                    state_d = S_OUT;
                end else if (last_accept) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_retire) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            len_q    <= '0;
            issue_q  <= '0;
            retire_q <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            tag_q    <= '0;
        end else begin
            tag_q <= tag_d;
            if ((state_q == S_IDLE) && START) begin
                len_q    <= len_cfg;
                issue_q  <= '0;
                retire_q <= '0;
                acc_q    <= '0;
            end else begin
                if (accept) begin
                    issue_q <= issue_q + 9'd1;
                end
                if (retire) begin
                    acc_q    <= acc_q + MAC_P;
                    retire_q <= retire_q + 9'd1;
                end
                // The result register takes the sum including the product
                // arriving in the final retire cycle.
                if (last_retire) begin
                    sum_q <= acc_q + MAC_P;
                end
            end
        end
    end

    assign IN_READY  = (state_q == S_FEED);
    assign BUSY      = (state_q != S_IDLE);
    assign MAC_SCLR  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_OUT);
    assign OUT_SUM   = sum_q;
    assign MAC_A     = accept ? IN_A : '0;
    assign MAC_B     = accept ? IN_B : '0;
    assign MAC_C     = '0;
    assign MAC_D     = '0;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb/tb_mac_dot_ctrl.sv - randomized self-checking bench for mac_dot_ctrl

module tb_mac_dot_ctrl;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [7:0]  CFG_LEN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [24:0] IN_A;
    logic [17:0] IN_B;
    logic [24:0] MAC_A;
    logic [17:0] MAC_B;
    logic [47:0] MAC_C;
    logic [24:0] MAC_D;
    logic        MAC_SCLR;
    logic [47:0] MAC_P;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [47:0] OUT_SUM;
    logic        BUSY;

    always #5 CLK = ~CLK;

    mac_dot_ctrl #(.MAC_LAT(LAT)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .CFG_LEN   (CFG_LEN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .MAC_A     (MAC_A),
        .MAC_B     (MAC_B),
        .MAC_C     (MAC_C),
        .MAC_D     (MAC_D),
        .MAC_SCLR  (MAC_SCLR),
        .MAC_P     (MAC_P),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_SUM   (OUT_SUM),
        .BUSY      (BUSY)
    );

    // External MAC stand-in: P = (A + D) * B + C, LAT cycles later.
    logic [47:0] mac_pipe [LAT];
    always @(posedge CLK) begin
        if (MAC_SCLR) begin
            for (int i = 0; i < LAT; i++) mac_pipe[i] <= '0;
        end else begin
            mac_pipe[0] <= 48'((longint'($signed(MAC_A)) + longint'($signed(MAC_D)))
                               * longint'($signed(MAC_B)) + longint'($signed(MAC_C)));
            for (int i = 1; i < LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
        end
    end
    assign MAC_P = mac_pipe[LAT-1];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a run is busy from START until the result is taken;
    // it accepts exactly len pairs, and the result appears LAT+1 cycles after
    // the final accept, carrying the wrapped sum of products.
    bit          m_busy = 0;
    bit          m_feed = 0;
    bit          m_out  = 0;
    int          m_len  = 0;
    int          m_cnt  = 0;
    int          m_done = 0;
    logic [47:0] m_sum  = '0;

    // Observations of the DUT used by the directed literal checks.
    int          last_acc_cyc = 0;
    int          rise_lat     = 0;
    int          pulses       = 0;
    int          acc_cnt      = 0;
    logic [47:0] hs_sum       = '0;
    bit          prev_ov      = 0;

    always @(negedge CLK) begin
        bit acc;
        cyc++;
        if (!RST_N) begin
            chk("rst_ctl", {IN_READY, BUSY, OUT_VALID, MAC_SCLR}, 4'b0001);
            chk("rst_sum", OUT_SUM, 48'd0);
            chk("rst_mac", {MAC_A, MAC_B}, 43'd0);
            m_busy  = 0;
            m_feed  = 0;
            m_out   = 0;
            prev_ov = 0;
        end else begin
            acc = m_feed && IN_VALID;
            chk("in_ready", IN_READY, m_feed);
            chk("busy", BUSY, m_busy);
            chk("mac_sclr", MAC_SCLR, !m_busy);
            chk("out_valid", OUT_VALID, m_out);
            chk("mac_ab", {MAC_A, MAC_B}, acc ? {IN_A, IN_B} : 43'd0);
            chk("mac_c", MAC_C, 48'd0);
            chk("mac_d", MAC_D, 25'd0);
            if (m_out) chk("out_sum", OUT_SUM, m_sum);

            if (IN_VALID && IN_READY) begin
                last_acc_cyc = cyc;
                acc_cnt++;
            end
            if (OUT_VALID && !prev_ov) begin
                pulses++;
                rise_lat = cyc - last_acc_cyc;
            end
            prev_ov = OUT_VALID;
            if (OUT_VALID && OUT_READY) hs_sum = OUT_SUM;

            if (m_out) begin
                if (OUT_READY) begin
                    m_out  = 0;
                    m_busy = 0;
                end
            end else if (!m_busy) begin
                if (START) begin
                    m_busy = 1;
                    m_feed = 1;
                    m_len  = (CFG_LEN == 8'd0) ? 256 : int'(CFG_LEN);
                    m_cnt  = 0;
                    m_sum  = '0;
                end
            end else if (m_feed) begin
                if (IN_VALID) begin
                    m_sum += 48'(longint'($signed(IN_A)) * longint'($signed(IN_B)));
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_feed = 0;
                        m_done = cyc + LAT + 1;
                    end
                end
            end else if (cyc + 1 == m_done) begin
                m_out = 1;
            end
        end
    end

    logic [24:0] qa [$];
    logic [17:0] qb [$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic add_pair(input int a, input int b);
        qa.push_back(25'(a));
        qb.push_back(18'(b));
    endtask

    task automatic start_run(input logic [7:0] len);
        tick();
        START   = 1'b1;
        CFG_LEN = len;
        tick();
        START   = 1'b0;
        CFG_LEN = 8'($urandom);
    endtask

    // gap_mode: 0 back-to-back, 1 bubble before every pair but the first,
    // 2 random bubbles. extra keeps IN_VALID high one cycle past the run.
    task automatic feed_pairs(input int n, input int gap_mode, input bit noise, input bit extra);
        for (int i = 0; i < n; i++) begin
            if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(99) < 30)) begin
                IN_VALID = 1'b0;
                IN_A     = 25'($urandom);
                IN_B     = 18'($urandom);
                START    = noise & 1'($urandom);
                tick();
            end
            IN_VALID = 1'b1;
            IN_A     = qa[i];
            IN_B     = qb[i];
            START    = noise & 1'($urandom);
            tick();
        end
        START = 1'b0;
        if (extra) begin
            IN_VALID = 1'b1;
            IN_A     = 25'($urandom);
            IN_B     = 18'($urandom);
            tick();
        end
        IN_VALID = 1'b0;
    endtask

    // rdy_mode: 0 ready always, 1 random ready, 2 ready only after hold
    // result cycles, with one START pulse during the hold.
    task automatic wait_out(input int rdy_mode, input int hold);
        int  seen = 0;
        bit  ok   = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       OUT_READY = 1'b1;
                1:       OUT_READY = 1'($urandom);
                default: OUT_READY = (seen >= hold);
            endcase
            IN_VALID = 1'($urandom);
            IN_A     = 25'($urandom);
            IN_B     = 18'($urandom);
            START    = (rdy_mode == 2) ? (seen == 3) : (rdy_mode == 1 && 1'($urandom));
            @(negedge CLK);
            if (OUT_VALID) seen++;
            if (OUT_VALID && OUT_READY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("out_timeout", 64'd0, 64'd1);
        tick();
        START     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
    endtask

    initial begin
        RST_N     = 1'b0;
        START     = 1'b0;
        CFG_LEN   = 8'd0;
        IN_VALID  = 1'b0;
        IN_A      = '0;
        IN_B      = '0;
        OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_sclr", MAC_SCLR, 1'b1);
        chk("reset_in_ready", IN_READY, 1'b0);

        // Three back-to-back pairs, result consumed immediately.
        qa.delete(); qb.delete();
        add_pair(2, 3); add_pair(-4, 5); add_pair(7, -1);
        pulses = 0;
        start_run(8'd3);
        feed_pairs(3, 0, 1'b0, 1'b0);
        wait_out(0, 0);
        chk("len3_sum", hs_sum, 48'hFFFF_FFFF_FFEB);
        chk("len3_model_sum", m_sum, 48'hFFFF_FFFF_FFEB);
        chk("len3_latency", rise_lat, 5);
        chk("len3_pulses", pulses, 1);

        // Largest positive operands.
        qa.delete(); qb.delete();
        add_pair(16777215, 131071);
        start_run(8'd1);
        feed_pairs(1, 0, 1'b0, 1'b0);
        wait_out(1, 0);
        chk("max_sum", hs_sum, 48'd2199006347265);

        // Same three pairs with a bubble between each.
        qa.delete(); qb.delete();
        add_pair(2, 3); add_pair(-4, 5); add_pair(7, -1);
        start_run(8'd3);
        feed_pairs(3, 1, 1'b0, 1'b0);
        wait_out(0, 0);
        chk("gap_sum", hs_sum, 48'hFFFF_FFFF_FFEB);

        // Result held back ten cycles with a START pulse while waiting.
        pulses = 0;
        start_run(8'd3);
        feed_pairs(3, 0, 1'b0, 1'b0);
        wait_out(2, 10);
        chk("hold_sum", hs_sum, 48'hFFFF_FFFF_FFEB);
        chk("hold_pulses", pulses, 1);
        chk("hold_idle_after", BUSY, 1'b0);

        // Reset after two of four pairs, then a fresh short run.
        qa.delete(); qb.delete();
        for (int i = 0; i < 4; i++) add_pair(1, 1);
        pulses = 0;
        start_run(8'd4);
        feed_pairs(2, 0, 1'b0, 1'b0);
        IN_VALID = 1'b1;
        IN_A     = 25'd5;
        IN_B     = 18'd3;
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_ctl", {IN_READY, BUSY, OUT_VALID, MAC_SCLR}, 4'b0001);
        chk("async_rst_sum", OUT_SUM, 48'd0);
        chk("async_rst_mac", {MAC_A, MAC_B}, 43'd0);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        #1 RST_N = 1'b1;
        start_run(8'd2);
        feed_pairs(2, 0, 1'b0, 1'b0);
        wait_out(0, 0);
        chk("post_rst_sum", hs_sum, 48'd2);
        chk("post_rst_pulses", pulses, 1);

        // Full-length run, with a 257th valid offered.
        qa.delete(); qb.delete();
        for (int i = 0; i < 256; i++) add_pair(1, 1);
        acc_cnt = 0;
        start_run(8'd0);
        feed_pairs(256, 0, 1'b0, 1'b1);
        wait_out(0, 0);
        chk("len256_sum", hs_sum, 48'd256);
        chk("len256_accepts", acc_cnt, 256);

        // Randomized runs checked against the model every cycle.
        for (int r = 0; r < 40; r++) begin
            int len;
            len = $urandom_range(1, 24);
            qa.delete(); qb.delete();
            for (int i = 0; i < len; i++) add_pair(int'($urandom), int'($urandom));
            start_run(8'(len));
            feed_pairs(len, 2, 1'b1, 1'($urandom));
            wait_out(1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: time limit reached before the end of stimulus");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_dot_ctrl.md
MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

Interface
REQ-001 Parameter MAC_LAT, default 4: cycles from operands on MAC_A/B/C/D to the matching result on MAC_P.
REQ-002 CLK  in  1  the only clock; all sequential logic on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-004 START  in  1  pulse that begins one dot product; honoured in IDLE only.
REQ-005 CFG_LEN  in  8  products per dot product; sampled on accepted START; 0 means 256.
REQ-006 IN_VALID  in  1  operand pair valid.
REQ-007 IN_READY  out  1  operand pair accepted when IN_VALID && IN_READY.
REQ-008 IN_A  in  25  signed multiplicand.
REQ-009 IN_B  in  18  signed multiplier.
REQ-010 MAC_A  out  25  to MAC A port.
REQ-011 MAC_B  out  18  to MAC B port.
REQ-012 MAC_C  out  48  to MAC C port; always 0.
REQ-013 MAC_D  out  25  to MAC D port; always 0.
REQ-014 MAC_SCLR  out  1  synchronous clear to MAC.
REQ-015 MAC_P  in  48  signed MAC result.
REQ-016 OUT_VALID  out  1  OUT_SUM valid.
REQ-017 OUT_READY  in  1  result consumed when OUT_VALID && OUT_READY.
REQ-018 OUT_SUM  out  48  signed dot-product result.
REQ-019 BUSY  out  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, FEED, DRAIN, OUT.
REQ-021 IDLE: MAC_SCLR=1, IN_READY=0; START -> FEED, latch CFG_LEN, clear accumulator, issue count and retire count.
REQ-022 FEED: MAC_SCLR=0, IN_READY=1; on accept, MAC_A=IN_A and MAC_B=IN_B combinationally in that cycle; otherwise MAC_A=MAC_B=0.
REQ-023 FEED: accept of the final pair (issue count reaches length) -> DRAIN; IN_READY=0 from the next cycle.
REQ-024 Tag shift register of MAC_LAT bits: bit0 loads the accept flag each edge; bits shift by one each edge.
REQ-025 When the top tag bit is 1, next edge: accumulator += MAC_P; retire count increments.
REQ-026 Accumulator is 48-bit two's complement; overflow wraps modulo 2^48.
REQ-027 Final retire moves FSM to OUT and loads OUT_SUM with the final sum, including that last product.
REQ-028 Final retire occurs in FEED or DRAIN.
REQ-029 OUT_VALID rises MAC_LAT+1 cycles after the cycle of the last accept.
REQ-030 OUT: OUT_VALID=1; OUT_SUM is held stable until the handshake, then FSM -> IDLE.
REQ-031 OUT_VALID falls the cycle after the handshake.
REQ-032 START outside IDLE is ignored.
REQ-033 IN_VALID outside FEED is ignored.
REQ-034 IN_VALID gaps in FEED insert bubbles only; the result is unchanged.
REQ-035 OUT_READY high in the same cycle OUT_VALID rises gives a 1-cycle OUT state.

Reset
REQ-036 RST_N low forces immediately: state IDLE; accumulator, counts and tags 0.
REQ-037 RST_N low forces immediately: OUT_VALID=0, OUT_SUM=0, IN_READY=0, BUSY=0, MAC_A=MAC_B=0.
REQ-038 While RST_N is low, MAC_SCLR=1.
REQ-039 Reset mid-operation abandons the run with no output.
REQ-040 The first START after release runs normally.

Verification
REQ-041 CFG_LEN=3, pairs (2,3),(-4,5),(7,-1) back-to-back, OUT_READY=1 -> OUT_SUM=-21, one OUT_VALID pulse 5 cycles after the last accept.
REQ-042 CFG_LEN=1, IN_A=16777215, IN_B=131071 -> OUT_SUM=2199006347265.
REQ-043 Same as REQ-041 with IN_VALID low every other cycle -> OUT_SUM=-21; IN_READY stays 1 throughout FEED.
REQ-044 OUT_READY held low 10 cycles after OUT_VALID; START pulsed meanwhile -> OUT_SUM stable, IN_READY=0, BUSY=1, START ignored; FSM returns to IDLE one cycle after OUT_READY=1.
REQ-045 RST_N pulsed low after 2 of 4 pairs -> all outputs 0 asynchronously; new run CFG_LEN=2, (1,1),(1,1) -> OUT_SUM=2.
REQ-046 CFG_LEN=0 with 256 pairs of (1,1) -> OUT_SUM=256; the 257th IN_VALID is not accepted.
